// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
// Holds the loader state encoding, default memory geometry and the nop word
// returned to the CPU on illegal fetches or while it is held.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEPTH_DEF  = 128;
  localparam int ADDR_W_DEF = 7;

  localparam logic [31:0] NOP_WORD = 32'h00000000;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program loader and fetch-port arbiter for the instruction RAM
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               pulse that (re)starts a load from word 0
//   s_valid/s_ready     load stream handshake; s_data word, s_last final word
//   cpu_addr/cpu_inst   CPU fetch byte address and returned instruction
//   cpu_hold            keeps the CPU in reset outside RUN
//   mem_we/mem_addr/mem_wdata/mem_rdata  external RAM port (combinational read)
//   load_count          words written by the current or last load
//   done/err            RUN / overflow state flags
//   fetch_fault         sticky flag for misaligned or out-of-range fetches
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_inst,
  output logic              cpu_hold,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W:0]   load_count,
  output logic              done,
  output logic              err,
  output logic              fetch_fault
);

  // load_count is one bit wider than the address so it can represent a full memory
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W+1)'(1);

  state_t state;
  logic   in_load;
  logic   in_run;
  logic   fetch_bad;
  logic   accept;

  assign in_load = (state == LOAD);
  assign in_run  = (state == RUN);

  // Misaligned, or beyond the byte range covered by the RAM
  assign fetch_bad = (cpu_addr[1:0] != 2'b00) || (cpu_addr[31:ADDR_W+2] != '0);

  // start takes priority over a beat presented in the same cycle
  assign s_ready = in_load && !start && (load_count < FULL_COUNT);
  assign accept  = s_valid && s_ready;

  assign mem_we    = accept;
  assign mem_wdata = s_data;
  assign mem_addr  = in_run ? cpu_addr[ADDR_W+1:2] : load_count[ADDR_W-1:0];
  assign cpu_inst  = (in_run && !fetch_bad) ? mem_rdata : NOP_WORD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      load_count  <= '0;
      cpu_hold    <= 1'b1;
      fetch_fault <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else if (start) begin
      state       <= LOAD;
      load_count  <= '0;
      fetch_fault <= 1'b0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            load_count <= load_count + COUNT_ONE;
            if (s_last) begin
              state    <= RUN;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end else if (s_valid && (load_count == FULL_COUNT)) begin
            // Program longer than the memory: park until a new start
            state <= ERR;
            err   <= 1'b1;
          end
        end
        RUN: begin
          if (fetch_bad) begin
            fetch_fault <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a behavioural RAM model
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  localparam logic [31:0] PROG [6] = '{
    32'h00221820, 32'hAC010000, 32'h8C240000,
    32'h10210001, 32'h00001820, 32'h00411822
  };

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic              s_last = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_inst;
  logic              cpu_hold;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [ADDR_W:0]   load_count;
  logic              done;
  logic              err;
  logic              fetch_fault;

  logic [31:0] ram [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int          exp_count;
  int          checks = 0;
  int          fails = 0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cpu_addr(cpu_addr), .cpu_inst(cpu_inst), .cpu_hold(cpu_hold),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_count(load_count), .done(done), .err(err), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction RAM: synchronous write, combinational read
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    tick();
    start = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (load_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", load_count); end
    checks++; if ({cpu_hold, done, err, fetch_fault} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got hold/done/err/ff=%b want 1000", {cpu_hold, done, err, fetch_fault});
    end
    checks++; if ({s_ready, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_stream: got ready/we=%b want 00", {s_ready, mem_we}); end
    checks++; if (cpu_inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", cpu_inst); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_sequence();
    int bad;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data = PROG[i];
      s_last = (i == 5);
      #1;
      checks++; if ({s_ready, mem_we, mem_addr} !== {2'b11, 7'(i)}) begin
        fails++; $display("FAIL load_beat%0d: got ready/we/addr=%b/%b/%0d want 1/1/%0d", i, s_ready, mem_we, mem_addr, i);
      end
      if (i == 5) begin
        checks++; if ({done, cpu_hold} !== 2'b01) begin fails++; $display("FAIL load_hold_before_last: got done/hold=%b want 01", {done, cpu_hold}); end
      end
      exp_mem[i] = PROG[i];
      exp_count++;
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    checks++; if (load_count !== 8'(exp_count)) begin fails++; $display("FAIL load_count: got %0d want %0d", load_count, exp_count); end
    checks++; if ({done, cpu_hold, err} !== 3'b100) begin fails++; $display("FAIL load_run: got done/hold/err=%b want 100", {done, cpu_hold, err}); end
    bad = 0;
    for (int i = 0; i < 6; i++) if (ram[i] !== PROG[i]) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL load_ram: got %0d wrong words want 0", bad); end
  endtask

  task automatic test_fetch();
    cpu_addr = 32'h0000000C;
    #1;
    checks++; if (cpu_inst !== 32'h10210001) begin fails++; $display("FAIL fetch_0c: got %h want 10210001", cpu_inst); end
    tick();
    checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL fetch_ff_legal: got %b want 0", fetch_fault); end
    cpu_addr = 32'h0000000D;
    #1;
    checks++; if (cpu_inst !== 32'h0) begin fails++; $display("FAIL fetch_0d: got %h want 0", cpu_inst); end
    tick();
    checks++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL fetch_ff_misalign: got %b want 1", fetch_fault); end
    cpu_addr = 32'h00000200;
    #1;
    checks++; if (cpu_inst !== 32'h0) begin fails++; $display("FAIL fetch_200: got %h want 0", cpu_inst); end
    cpu_addr = 32'h00000014;
    #1;
    checks++; if (cpu_inst !== 32'h00411822) begin fails++; $display("FAIL fetch_14: got %h want 00411822", cpu_inst); end
    tick();
    checks++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL fetch_ff_sticky: got %b want 1", fetch_fault); end
    cpu_addr = '0;
  endtask

  task automatic test_overflow();
    int bad;
    pulse_start();
    checks++; if ({fetch_fault, done, cpu_hold} !== 3'b001) begin fails++; $display("FAIL ovf_start_flags: got ff/done/hold=%b want 001", {fetch_fault, done, cpu_hold}); end
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data = $urandom;
      s_last = 1'b0;
      exp_mem[i] = s_data;
      exp_count++;
      tick();
    end
    #1;
    checks++; if (load_count !== 8'(exp_count)) begin fails++; $display("FAIL ovf_count: got %0d want %0d", load_count, exp_count); end
    checks++; if ({s_ready, mem_we} !== 2'b00) begin fails++; $display("FAIL ovf_ready: got ready/we=%b want 00", {s_ready, mem_we}); end
    tick();
    checks++; if ({err, done, cpu_hold} !== 3'b101) begin fails++; $display("FAIL ovf_err: got err/done/hold=%b want 101", {err, done, cpu_hold}); end
    tick();
    checks++; if ({err, load_count} !== {1'b1, 8'd128}) begin fails++; $display("FAIL ovf_hold: got err=%b count=%0d want 1/128", err, load_count); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL ovf_ram: got %0d wrong words want 0", bad); end
    pulse_start();
    #1;
    checks++; if ({load_count, err, cpu_hold, s_ready} !== {8'd0, 3'b011}) begin
      fails++; $display("FAIL ovf_recover: got count=%0d err/hold/ready=%b want 0/011", load_count, {err, cpu_hold, s_ready});
    end
  endtask

  task automatic test_backpressure_collision();
    logic pat [3] = '{1'b1, 1'b0, 1'b1};
    int bad;
    for (int i = 0; i < 3; i++) begin
      s_valid = pat[i];
      s_data = $urandom;
      if (pat[i]) begin
        exp_mem[exp_count] = s_data;
        exp_count++;
      end
      tick();
    end
    s_valid = 1'b0;
    checks++; if (load_count !== 8'(exp_count)) begin fails++; $display("FAIL bp_count: got %0d want %0d", load_count, exp_count); end
    bad = 0;
    for (int i = 0; i < 3; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL bp_ram: got %0d wrong words want 0", bad); end
    start = 1'b1;
    s_valid = 1'b1;
    s_data = ~exp_mem[2];
    #1;
    checks++; if ({s_ready, mem_we} !== 2'b00) begin fails++; $display("FAIL coll_ready: got ready/we=%b want 00", {s_ready, mem_we}); end
    tick();
    start = 1'b0;
    s_valid = 1'b0;
    exp_count = 0;
    checks++; if (load_count !== '0) begin fails++; $display("FAIL coll_count: got %0d want 0", load_count); end
    checks++; if (ram[2] !== exp_mem[2]) begin fails++; $display("FAIL coll_ram: got %h want %h", ram[2], exp_mem[2]); end
  endtask

  task automatic test_reset_midload();
    int bad;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = $urandom;
      exp_mem[i] = s_data;
      tick();
    end
    s_data = ~exp_mem[3];
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({load_count, cpu_hold, done, s_ready, mem_we} !== {8'd0, 4'b1000}) begin
      fails++; $display("FAIL rst_mid_async: got count=%0d hold/done/ready/we=%b want 0/1000", load_count, {cpu_hold, done, s_ready, mem_we});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (load_count !== '0) begin fails++; $display("FAIL rst_mid_idle: got %0d want 0", load_count); end
    s_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL rst_mid_ram: got %0d wrong words want 0", bad); end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 5; it++) begin
      int len;
      int n;
      int cyc;
      logic exp_ff;
      logic v;
      logic [31:0] a;
      logic [31:0] want;
      pulse_start();
      checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL rnd%0d_ff_clear: got %b want 0", it, fetch_fault); end
      len = $urandom_range(1, 24);
      n = 0;
      cyc = 0;
      while (n < len && cyc < 200) begin
        v = ($urandom_range(0, 3) != 0);
        s_valid = v;
        s_data = $urandom;
        s_last = v && (n == len - 1);
        #1;
        checks++; if (mem_we !== v) begin fails++; $display("FAIL rnd%0d_we: got %b want %b", it, mem_we, v); end
        if (v) begin
          exp_mem[n] = s_data;
          n++;
        end
        tick();
        cyc++;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      checks++; if (n !== len) begin fails++; $display("FAIL rnd%0d_budget: got %0d beats want %0d", it, n, len); end
      checks++; if ({done, cpu_hold, load_count} !== {2'b10, 8'(len)}) begin
        fails++; $display("FAIL rnd%0d_run: got done/hold=%b count=%0d want 10/%0d", it, {done, cpu_hold}, load_count, len);
      end
      exp_ff = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) != 0) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        else a = $urandom;
        want = ((a % 4 == 0) && (a < 32'(DEPTH * 4))) ? exp_mem[a / 4] : 32'h0;
        if (!((a % 4 == 0) && (a < 32'(DEPTH * 4)))) exp_ff = 1'b1;
        cpu_addr = a;
        #1;
        checks++; if (cpu_inst !== want) begin fails++; $display("FAIL rnd%0d_fetch: addr %h got %h want %h", it, a, cpu_inst, want); end
        tick();
        checks++; if (fetch_fault !== exp_ff) begin fails++; $display("FAIL rnd%0d_ff: addr %h got %b want %b", it, a, fetch_fault, exp_ff); end
      end
      cpu_addr = '0;
    end
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_fetch();
    test_overflow();
    test_backpressure_collision();
    test_reset_midload();
    test_random_loads();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and access controller for the CPU's 128-word instruction memory. It accepts a word stream over a valid/ready port and writes it into memory from word 0 upward, holding the CPU in reset while loading. After a load completes, it hands the memory read port to the CPU fetch path. It sits between the top level, the instruction RAM instance and the single-cycle core.

## Interface
- DEPTH, 128, instruction memory depth in 32-bit words; power of two
- ADDR_W, 7, word-address width, equal to log2(DEPTH)
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a new load
- s_valid  in  1  load-stream word valid
- s_ready  out  1  loader accepts a word this cycle
- s_data  in  32  instruction word
- s_last  in  1  marks the final word of the program
- cpu_addr  in  32  CPU fetch byte address (PC)
- cpu_inst  out  32  instruction returned to the CPU
- cpu_hold  out  1  holds the CPU in reset while high
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data; combinational read of mem_addr
- load_count  out  ADDR_W+1  number of words written by the current or last load
- done  out  1  high while in RUN
- err  out  1  high while in ERR (overflow)
- fetch_fault  out  1  sticky flag for misaligned or out-of-range fetches

## Operation
- States: IDLE, LOAD, RUN, ERR.
- Reset values:
  - state = IDLE, load_count = 0, cpu_hold = 1, fetch_fault = 0.
  - done = 0, err = 0, s_ready = 0, mem_we = 0.
- IDLE: CPU held. start moves to LOAD.
- LOAD:
  - s_ready = !start && (load_count < DEPTH).
  - A beat is accepted when s_valid && s_ready.
  - On an accepted beat: mem_we = 1, mem_addr = load_count[ADDR_W-1:0], mem_wdata = s_data, and load_count increments.
  - An accepted beat with s_last moves to RUN.
  - s_valid while load_count == DEPTH (no s_last seen) moves to ERR; nothing is written.
- RUN:
  - mem_we = 0, mem_addr = cpu_addr[ADDR_W+1:2].
  - cpu_inst = mem_rdata if the fetch is legal, otherwise 32'h00000000 (nop).
  - A fetch is illegal if cpu_addr[1:0] != 0 or cpu_addr[31:ADDR_W+2] != 0; an illegal fetch sets fetch_fault.
- ERR: CPU held, s_ready = 0. Only start or reset leaves this state.
- start in any state moves to LOAD:
  - load_count clears to 0 and fetch_fault clears.
  - No beat is accepted in the start cycle (start wins over a simultaneous beat).
- Outside RUN, cpu_inst = 0. mem_addr = load_count[ADDR_W-1:0] when not writing.
- cpu_hold = 0 only in RUN.
- Reset mid-load returns to IDLE. RAM contents already written are kept; the loader does not clear them.

## Timing
- RAM write takes effect on the same clock edge as the accepted beat.
- Load throughput: one word per cycle while s_valid is held.
- The RUN read path is combinational: cpu_addr to cpu_inst has zero-cycle latency, matching the single-cycle core.
- done rises and cpu_hold falls in the cycle after the s_last beat. They are registered state outputs, glitch-free.
- load_count updates on the edge of each accepted beat and holds its value through RUN and ERR.
- fetch_fault is set on the edge following an illegal-fetch cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, ERR=3),
  - DEPTH and ADDR_W defaults,
  - the NOP word constant 32'h00000000.
- No sub-module: the RAM is instantiated separately by the top level and connected through the mem_* ports.
- Single FSM with a counter and a combinational output mux.

## Test plan
- Load sequence: reset, start, then 6 beats 00221820, AC010000, 8C240000, 10210001, 00001820, 00411822 with s_last on the 6th.
  - Required: RAM words 0..5 hold those values, load_count = 6, done = 1 and cpu_hold = 0 one cycle after the last beat.
- Fetch in RUN:
  - cpu_addr = 0x0C returns 10210001 in the same cycle.
  - cpu_addr = 0x0D returns 0 and sets fetch_fault.
  - cpu_addr = 0x200 returns 0.
- Overflow: 128 beats without s_last, then one more s_valid.
  - Required: 128 words written, s_ready = 0 at count 128, state ERR with err = 1, cpu_hold = 1.
  - Recovery: start returns to LOAD with load_count = 0.
- Backpressure and collision: s_valid toggling 1,0,1 writes exactly 2 words. start coinciding with a valid beat writes nothing in that cycle.
- Reset mid-load: assert reset after 3 beats.
  - Required: IDLE immediately (async), load_count = 0, cpu_hold = 1, RAM words 0..2 unchanged.
